// File: rtl/regfile_param.sv
// Parametrised two-read/one-write register file with write-to-read bypass,
// optional hardwired-zero r0, per-register pending scoreboard and a sequenced clear engine.
module regfile_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             WriteEn,
  input  logic [AW-1:0]    Waddr,
  input  logic [WIDTH-1:0] DataIn,
  input  logic [AW-1:0]    RaddrA,
  input  logic [AW-1:0]    RaddrB,
  output logic [WIDTH-1:0] DataOutA,
  output logic [WIDTH-1:0] DataOutB,
  input  logic             SetPend,
  input  logic [AW-1:0]    SetPendAddr,
  output logic             StallA,
  output logic             StallB,
  input  logic             ClearReq,
  output logic             WriteReady,
  output logic             ClearDone
);

  localparam bit ZR = (ZERO_REG != 0);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;
  logic             done_q, done_d;

  logic write_ok_s;
  logic set_ok_s;

  // Writes and pending marks are only accepted in IDLE, never to a hardwired r0.
  always_comb begin
    write_ok_s = WriteEn && (state_q == ST_IDLE) && !(ZR && (Waddr == AW'(0)));
    set_ok_s   = SetPend && (state_q == ST_IDLE) && !(ZR && (SetPendAddr == AW'(0)));
  end

  // Read port A: hardwired zero overrides bypass, bypass overrides the array.
  always_comb begin
    if (ZR && (RaddrA == AW'(0))) begin
      DataOutA = '0;
    end else if (write_ok_s && (Waddr == RaddrA)) begin
      DataOutA = DataIn;
    end else begin
      DataOutA = mem_q[RaddrA];
    end
    StallA = (state_q == ST_IDLE) && pend_q[RaddrA] && !(write_ok_s && (Waddr == RaddrA));
  end

  // Read port B: same priority as port A.
  always_comb begin
    if (ZR && (RaddrB == AW'(0))) begin
      DataOutB = '0;
    end else if (write_ok_s && (Waddr == RaddrB)) begin
      DataOutB = DataIn;
    end else begin
      DataOutB = mem_q[RaddrB];
    end
    StallB = (state_q == ST_IDLE) && pend_q[RaddrB] && !(write_ok_s && (Waddr == RaddrB));
  end

  // Next-state logic for the array, scoreboard and clear sequencer.
  always_comb begin
    mem_d   = mem_q;
    pend_d  = pend_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (write_ok_s) begin
          mem_d[Waddr]  = DataIn;
          pend_d[Waddr] = 1'b0;
        end else begin
          pend_d = pend_q;
        end
        // Set after clear so a same-cycle new producer keeps the bit high.
        if (set_ok_s) begin
          pend_d[SetPendAddr] = 1'b1;
        end else begin
          pend_d = pend_d;
        end
        if (ClearReq) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          pend_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        mem_d[cnt_q] = '0;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      mem_q   <= mem_d;
    end
  end

  assign WriteReady = (state_q == ST_IDLE);
  assign ClearDone  = done_q;

endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param: a default build plus a ZERO_REG=1 build
// sharing the same stimulus.
module tb_regfile_param;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       WriteEn;
  logic [2:0] Waddr;
  logic [7:0] DataIn;
  logic [2:0] RaddrA;
  logic [2:0] RaddrB;
  logic       SetPend;
  logic [2:0] SetPendAddr;
  logic       ClearReq;
  logic [7:0] DataOutA, DataOutB;
  logic       StallA, StallB, WriteReady, ClearDone;
  logic [7:0] z_DataOutA, z_DataOutB;
  logic       z_StallA, z_StallB, z_WriteReady, z_ClearDone;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  regfile_param #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0)) u_dut (
    .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
    .RaddrA(RaddrA), .RaddrB(RaddrB), .DataOutA(DataOutA), .DataOutB(DataOutB),
    .SetPend(SetPend), .SetPendAddr(SetPendAddr), .StallA(StallA), .StallB(StallB),
    .ClearReq(ClearReq), .WriteReady(WriteReady), .ClearDone(ClearDone)
  );

  regfile_param #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1)) u_zero (
    .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
    .RaddrA(RaddrA), .RaddrB(RaddrB), .DataOutA(z_DataOutA), .DataOutB(z_DataOutB),
    .SetPend(SetPend), .SetPendAddr(SetPendAddr), .StallA(z_StallA), .StallB(z_StallB),
    .ClearReq(ClearReq), .WriteReady(z_WriteReady), .ClearDone(z_ClearDone)
  );

  task automatic idle_inputs();
    WriteEn = 1'b0; Waddr = 3'd0; DataIn = 8'd0; RaddrA = 3'd0; RaddrB = 3'd0;
    SetPend = 1'b0; SetPendAddr = 3'd0; ClearReq = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    #1;
    checks++; if (WriteReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", WriteReady); end
    checks++; if (ClearDone !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", ClearDone); end
    checks++; if (DataOutA !== 8'd0 || StallA !== 1'b0) begin errors++; $display("FAIL reset_read: got %0h/%b expected 0/0", DataOutA, StallA); end
    Reset = 1'b0;
  endtask

  task automatic test_write_read();
    @(negedge Clk); WriteEn = 1'b1; Waddr = 3'd2; DataIn = 8'd22;
    @(negedge Clk); Waddr = 3'd3; DataIn = 8'd16;
    @(negedge Clk); WriteEn = 1'b0; RaddrA = 3'd2; RaddrB = 3'd3;
    #1;
    checks++; if (DataOutA !== 8'd22) begin errors++; $display("FAIL wr_read_a: got %0d expected 22", DataOutA); end
    checks++; if (DataOutB !== 8'd16) begin errors++; $display("FAIL wr_read_b: got %0d expected 16", DataOutB); end
    checks++; if (StallA !== 1'b0 || StallB !== 1'b0) begin errors++; $display("FAIL wr_read_stall: got %b%b expected 00", StallA, StallB); end
  endtask

  task automatic test_bypass();
    @(negedge Clk); RaddrA = 3'd7; RaddrB = 3'd7;
    #1;
    checks++; if (DataOutA !== 8'd0) begin errors++; $display("FAIL byp_before: got %0d expected 0", DataOutA); end
    WriteEn = 1'b1; Waddr = 3'd7; DataIn = 8'd15;
    #1;
    checks++; if (DataOutA !== 8'd15) begin errors++; $display("FAIL byp_a: got %0d expected 15", DataOutA); end
    checks++; if (DataOutB !== 8'd15) begin errors++; $display("FAIL byp_b_same: got %0d expected 15", DataOutB); end
    @(negedge Clk); WriteEn = 1'b0; DataIn = 8'd0;
    #1;
    checks++; if (DataOutA !== 8'd15) begin errors++; $display("FAIL byp_stored: got %0d expected 15", DataOutA); end
  endtask

  task automatic test_scoreboard();
    @(negedge Clk); SetPend = 1'b1; SetPendAddr = 3'd1; RaddrA = 3'd1;
    @(negedge Clk); SetPend = 1'b0;
    #1;
    checks++; if (StallA !== 1'b1) begin errors++; $display("FAIL sb_stall: got %b expected 1", StallA); end
    WriteEn = 1'b1; Waddr = 3'd1; DataIn = 8'd8;
    #1;
    checks++; if (StallA !== 1'b0 || DataOutA !== 8'd8) begin errors++; $display("FAIL sb_bypass: got %b/%0d expected 0/8", StallA, DataOutA); end
    @(negedge Clk); WriteEn = 1'b0;
    #1;
    checks++; if (StallA !== 1'b0 || DataOutA !== 8'd8) begin errors++; $display("FAIL sb_cleared: got %b/%0d expected 0/8", StallA, DataOutA); end
    SetPend = 1'b1; SetPendAddr = 3'd4; WriteEn = 1'b1; Waddr = 3'd4; DataIn = 8'd33; RaddrB = 3'd4;
    @(negedge Clk); SetPend = 1'b0; WriteEn = 1'b0;
    #1;
    checks++; if (StallB !== 1'b1 || DataOutB !== 8'd33) begin errors++; $display("FAIL sb_set_wins: got %b/%0d expected 1/33", StallB, DataOutB); end
  endtask

  task automatic test_zero_reg();
    @(negedge Clk); WriteEn = 1'b1; Waddr = 3'd5; DataIn = 8'h5C;
    @(negedge Clk); Waddr = 3'd0; DataIn = 8'hAA; SetPend = 1'b1; SetPendAddr = 3'd0;
    RaddrA = 3'd0; RaddrB = 3'd5;
    #1;
    checks++; if (z_DataOutA !== 8'd0 || z_StallA !== 1'b0) begin errors++; $display("FAIL zr_bypass_block: got %0h/%b expected 0/0", z_DataOutA, z_StallA); end
    checks++; if (z_DataOutB !== 8'h5C) begin errors++; $display("FAIL zr_r5: got %0h expected 5c", z_DataOutB); end
    checks++; if (DataOutA !== 8'hAA) begin errors++; $display("FAIL nz_r0_bypass: got %0h expected aa", DataOutA); end
    @(negedge Clk); WriteEn = 1'b0; SetPend = 1'b0;
    #1;
    checks++; if (z_DataOutA !== 8'd0 || z_StallA !== 1'b0) begin errors++; $display("FAIL zr_after: got %0h/%b expected 0/0", z_DataOutA, z_StallA); end
    checks++; if (z_DataOutB !== 8'h5C) begin errors++; $display("FAIL zr_r5_after: got %0h expected 5c", z_DataOutB); end
    checks++; if (DataOutA !== 8'hAA || StallA !== 1'b1) begin errors++; $display("FAIL nz_r0_after: got %0h/%b expected aa/1", DataOutA, StallA); end
  endtask

  task automatic test_clear();
    int ready_low = 0;
    int done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk); WriteEn = 1'b1; Waddr = 3'(i); DataIn = 8'hFF;
    end
    @(negedge Clk); WriteEn = 1'b0; SetPend = 1'b1; SetPendAddr = 3'd2;
    @(negedge Clk); SetPendAddr = 3'd6;
    @(negedge Clk); SetPend = 1'b0; RaddrB = 3'd2; ClearReq = 1'b1;
    #1;
    checks++; if (StallB !== 1'b1) begin errors++; $display("FAIL clr_pre_pend: got %b expected 1", StallB); end
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      ClearReq = 1'b0;
      WriteEn = (i == 3); Waddr = 3'd3; DataIn = 8'h55;
      SetPend = (i == 3); SetPendAddr = 3'd5;
      RaddrA = 3'd3; RaddrB = 3'd6;
      #1;
      if (WriteReady === 1'b0) ready_low++;
      if (ClearDone === 1'b1) done_seen++;
      if (i == 3) begin
        checks++; if (DataOutA !== 8'hFF) begin errors++; $display("FAIL clr_no_bypass: got %0h expected ff", DataOutA); end
        checks++; if (StallB !== 1'b0) begin errors++; $display("FAIL clr_stall: got %b expected 0", StallB); end
      end
    end
    checks++; if (ready_low != 8) begin errors++; $display("FAIL clr_ready_low: got %0d cycles expected 8", ready_low); end
    @(negedge Clk); WriteEn = 1'b0; SetPend = 1'b0;
    #1;
    checks++; if (WriteReady !== 1'b1 || ClearDone !== 1'b1) begin errors++; $display("FAIL clr_done: got ready %b done %b expected 1/1", WriteReady, ClearDone); end
    if (ClearDone === 1'b1) done_seen++;
    @(negedge Clk);
    #1;
    if (ClearDone === 1'b1) done_seen++;
    checks++; if (done_seen != 1) begin errors++; $display("FAIL clr_done_pulses: got %0d expected 1", done_seen); end
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk); RaddrA = 3'(i); RaddrB = 3'(7 - i);
      #1;
      checks++;
      if (DataOutA !== 8'd0 || DataOutB !== 8'd0 || StallA !== 1'b0 || StallB !== 1'b0) begin
        errors++; $display("FAIL clr_zero_r%0d: got %0h %0h stall %b%b expected 0 0 stall 00", i, DataOutA, DataOutB, StallA, StallB);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int done_seen = 0;
    @(negedge Clk); WriteEn = 1'b1; Waddr = 3'd7; DataIn = 8'h11;
    @(negedge Clk); WriteEn = 1'b0; ClearReq = 1'b1; RaddrA = 3'd7;
    @(negedge Clk); ClearReq = 1'b0;
    @(negedge Clk);
    #1;
    checks++; if (WriteReady !== 1'b0) begin errors++; $display("FAIL mid_in_clear: got %b expected 0", WriteReady); end
    @(negedge Clk); Reset = 1'b1;
    #1;
    checks++; if (WriteReady !== 1'b1 || ClearDone !== 1'b0) begin errors++; $display("FAIL mid_reset: got ready %b done %b expected 1/0", WriteReady, ClearDone); end
    checks++; if (DataOutA !== 8'd0) begin errors++; $display("FAIL mid_r7: got %0h expected 0", DataOutA); end
    @(negedge Clk); Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (ClearDone !== 1'b0) done_seen++;
    end
    checks++; if (done_seen != 0) begin errors++; $display("FAIL mid_no_done: got %0d pulses expected 0", done_seen); end
    @(negedge Clk); WriteEn = 1'b1; Waddr = 3'd6; DataIn = 8'd9;
    @(negedge Clk); WriteEn = 1'b0; RaddrB = 3'd6;
    #1;
    checks++; if (DataOutB !== 8'd9) begin errors++; $display("FAIL mid_write_after: got %0d expected 9", DataOutB); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_zero_reg();
    test_clear();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the 8x8 two-read/one-write register file; generalised in width and depth.
- Adds same-cycle write-to-read bypass, an optional hardwired-zero register 0, and a per-register pending scoreboard that flags reads of not-yet-written registers.
- Adds a sequenced clear engine that zeroes the array one entry per cycle.
- Sits between decode (read addresses, pending marks) and writeback (write port) in the datapath.

Parameters:
- WIDTH, 8, data bits per register.
- DEPTH, 8, number of registers; power of two, minimum 2.
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes and pending marks.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- WriteEn  in  1  write strobe; honoured only when WriteReady=1.
- Waddr  in  log2(DEPTH)  write address.
- DataIn  in  WIDTH  write data.
- RaddrA  in  log2(DEPTH)  read address, port A.
- RaddrB  in  log2(DEPTH)  read address, port B.
- DataOutA  out  WIDTH  read data, port A (combinational).
- DataOutB  out  WIDTH  read data, port B (combinational).
- SetPend  in  1  mark register SetPendAddr as awaiting a producer.
- SetPendAddr  in  log2(DEPTH)  register to mark.
- StallA  out  1  RaddrA is pending and not bypassed this cycle.
- StallB  out  1  RaddrB is pending and not bypassed this cycle.
- ClearReq  in  1  start a sequenced clear; sampled only in IDLE.
- WriteReady  out  1  high in IDLE, low in CLEAR.
- ClearDone  out  1  one-cycle pulse when the clear completes.

Behaviour:
- Reset (asynchronous):
  - All registers = 0; all pending bits = 0.
  - FSM = IDLE; clear counter = 0.
  - ClearDone = 0; WriteReady = 1.
  - Reset asserted mid-clear aborts the clear immediately; no ClearDone pulse.
- Write:
  - Condition: WriteEn && WriteReady && !(ZERO_REG && Waddr==0).
  - mem[Waddr] <= DataIn at the edge.
  - The same edge clears pend[Waddr].
- Read (combinational, zero latency):
  - Normal case: DataOutX = mem[RaddrX].
  - Bypass: if the write condition is true and Waddr==RaddrX, DataOutX = DataIn.
  - If ZERO_REG and RaddrX==0, DataOutX = 0; this overrides bypass.
  - A read with RaddrA==RaddrB returns identical data on both ports.
- Scoreboard:
  - SetPend in IDLE sets pend[SetPendAddr] at the edge; ignored for register 0 when ZERO_REG.
  - SetPend and a write to the same address in the same cycle: set wins, so the bit ends 1 (new producer issued).
  - StallX = pend[RaddrX] && !(write condition && Waddr==RaddrX).
  - SetPend is ignored in CLEAR.
- FSM IDLE:
  - ClearReq=1 -> CLEAR; counter <= 0; all pending bits <= 0.
  - A write in the same cycle as ClearReq is still performed; the clear later overwrites it.
- FSM CLEAR:
  - Each cycle mem[counter] <= 0 and counter increments.
  - WriteReady=0; WriteEn and SetPend are ignored.
  - Reads return current array contents (partially cleared); bypass is inactive.
  - StallX = 0 throughout.
  - ClearReq is ignored while in CLEAR.
- CLEAR exit:
  - On the cycle that clears entry DEPTH-1: next state IDLE, ClearDone=1 for exactly the following cycle, counter wraps to 0.
  - The clear takes exactly DEPTH cycles; WriteReady returns high in the cycle ClearDone is high.
- Width rules:
  - Addresses are exactly log2(DEPTH) bits; no out-of-range addresses exist.
  - Data is not extended or truncated.

Test Plan:
- Reset, write 22 to r2 and 16 to r3 on successive cycles, then read A=2, B=3 -> DataOutA=22, DataOutB=16, StallA=StallB=0.
- Bypass: WriteEn=1, Waddr=7, DataIn=15, RaddrA=7 in the same cycle (r7 previously 0) -> DataOutA=15 combinationally before the edge; after the edge mem[7]=15.
- Scoreboard: SetPend r1; next cycle RaddrA=1 -> StallA=1. Write 8 to r1 with RaddrA=1 in that cycle -> StallA=0, DataOutA=8 bypassed; the following cycle pend[1]=0. Separately, SetPend and a write to r4 in the same cycle -> pend[4]=1.
- ZERO_REG=1 build: write 0xAA to r0 and SetPend r0 -> DataOutA=0 with RaddrA=0, StallA=0; r5 is unaffected.
- Clear with DEPTH=8 and all registers preloaded with 0xFF: pulse ClearReq -> WriteReady low for 8 cycles; WriteEn of 0x55 to r3 in cycle 4 is ignored; ClearDone pulses once; all registers read 0; pending bits = 0.
- Reset asserted in cycle 3 of a clear -> immediate IDLE, WriteReady=1, all registers 0, no ClearDone pulse; a write of 9 to r6 right after reset reads back 9.
